// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shader IDs, sequencer state encoding and saturating fade helpers
package shader_pkg;

  localparam logic [3:0] SH_RADIAL   = 4'd2;
  localparam logic [3:0] SH_CHECKER  = 4'd3;
  localparam logic [3:0] SH_SINE     = 4'd4;
  localparam logic [3:0] SH_TRIANGLE = 4'd6;
  localparam logic [3:0] SH_ROTATE   = 4'd7;
  localparam logic [3:0] SH_CIRCLES  = 4'd8;
  localparam logic [3:0] SH_CONV     = 4'd9;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_BLACK    = 2'd2;
  localparam logic [1:0] ST_FADE_IN  = 2'd3;

  localparam logic [7:0] FADE_MAX = 8'd255;

  // 9-bit arithmetic so the carry/borrow bit flags the clamp
  function automatic logic [7:0] fade_add(input logic [7:0] lvl, input logic [7:0] step);
    logic [8:0] sum;
    sum = {1'b0, lvl} + {1'b0, step};
    return sum[8] ? FADE_MAX : sum[7:0];
  endfunction

  function automatic logic [7:0] fade_sub(input logic [7:0] lvl, input logic [7:0] step);
    logic [8:0] diff;
    diff = {1'b0, lvl} - {1'b0, step};
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

endpackage

// File: rtl/fade_scaler.sv
// rtl/fade_scaler.sv - two-stage RGB x fade multiplier; out = ch * (fade + 1) >> 8
module fade_scaler
  import shader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [23:0] rgb_in,
  input  logic [7:0]  fade_in,
  output logic        valid_out,
  output logic [23:0] rgb_out
);

  logic [23:0] rgb_s1_q, rgb_s1_d;
  logic        valid_s1_q, valid_s1_d;
  logic [7:0]  fade_s1_q, fade_s1_d;
  logic [23:0] rgb_out_q, rgb_out_d;
  logic        valid_out_q, valid_out_d;

  // fade + 1 makes full brightness an exact pass-through (ch * 256 >> 8)
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] fade);
    logic [15:0] prod;
    prod = {8'd0, ch} * ({8'd0, fade} + 16'd1);
    return prod[15:8];
  endfunction

  always_comb begin
    rgb_s1_d    = rgb_in;
    valid_s1_d  = valid_in;
    fade_s1_d   = fade_in;
    valid_out_d = valid_s1_q;
    rgb_out_d   = {scale_ch(rgb_s1_q[23:16], fade_s1_q),
                   scale_ch(rgb_s1_q[15:8],  fade_s1_q),
                   scale_ch(rgb_s1_q[7:0],   fade_s1_q)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s1_q    <= '0;
      valid_s1_q  <= 1'b0;
      fade_s1_q   <= FADE_MAX;
      rgb_out_q   <= '0;
      valid_out_q <= 1'b0;
    end else begin
      rgb_s1_q    <= rgb_s1_d;
      valid_s1_q  <= valid_s1_d;
      fade_s1_q   <= fade_s1_d;
      rgb_out_q   <= rgb_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign rgb_out   = rgb_out_q;

endmodule

// File: rtl/shader_fade_sequencer.sv
// rtl/shader_fade_sequencer.sv - frame-synchronous shader/kernel commit with fade-out/black/fade-in
// SHADER_FADE_EN enables the fade sequence; without it selections commit directly at frame_start.
module shader_fade_sequencer
  import shader_pkg::*;
#(
  parameter int unsigned FADE_STEP    = 16,
  parameter int unsigned HOLD_FRAMES  = 1,
  parameter logic [3:0]  RESET_SHADER = SH_TRIANGLE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_shader,
  input  logic [1:0]  req_kernel,
  input  logic        frame_start,
  input  logic        pix_valid_in,
  input  logic [23:0] pix_rgb_in,
  output logic [3:0]  active_shader,
  output logic [1:0]  active_kernel,
  output logic [7:0]  fade_level,
  output logic        busy,
  output logic        pix_valid_out,
  output logic [23:0] pix_rgb_out
);

`ifdef SHADER_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  localparam logic [7:0] STEP8 = FADE_STEP[7:0];
  localparam logic [7:0] HOLD8 = HOLD_FRAMES[7:0];

  logic [1:0] state_q, state_d;
  logic [5:0] active_q, active_d;
  logic [7:0] fade_q, fade_d;
  logic [7:0] hold_q, hold_d;
  logic [5:0] pending;
  logic [7:0] fade_dn, fade_up;

  assign pending = {req_shader, req_kernel};

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    fade_d   = fade_q;
    hold_d   = hold_q;
    fade_dn  = fade_sub(fade_q, STEP8);
    fade_up  = fade_add(fade_q, STEP8);
    if (frame_start) begin
      if (!FADE_EN) begin
        if (pending != active_q) active_d = pending;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (pending != active_q) begin
              state_d = ST_FADE_OUT;
              fade_d  = fade_dn;
            end
          end
          ST_FADE_OUT: begin
            if (pending == active_q) begin
              state_d = ST_FADE_IN;
              fade_d  = fade_up;
            end else begin
              fade_d = fade_dn;
              if (fade_dn == 8'd0) begin
                state_d = ST_BLACK;
                hold_d  = HOLD8;
              end
            end
          end
          ST_BLACK: begin
            hold_d = hold_q - 8'd1;
            // commit the latest request so retargets during the fade win
            if (hold_q == 8'd1) begin
              active_d = pending;
              state_d  = ST_FADE_IN;
            end
          end
          default: begin
            if (pending != active_q) begin
              state_d = ST_FADE_OUT;
              fade_d  = fade_dn;
            end else begin
              fade_d = fade_up;
              if (fade_up == FADE_MAX) state_d = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      active_q <= {RESET_SHADER, 2'd0};
      fade_q   <= FADE_MAX;
      hold_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      fade_q   <= fade_d;
      hold_q   <= hold_d;
    end
  end

  assign active_shader = active_q[5:2];
  assign active_kernel = active_q[1:0];
  assign fade_level    = fade_q;
  assign busy          = (state_q != ST_IDLE);

  fade_scaler u_fade_scaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (pix_valid_in),
    .rgb_in    (pix_rgb_in),
    .fade_in   (fade_q),
    .valid_out (pix_valid_out),
    .rgb_out   (pix_rgb_out)
  );

endmodule

// File: tb/tb_shader_fade_sequencer.sv
// tb/tb_shader_fade_sequencer.sv - model-checked bench for shader_fade_sequencer (either SHADER_FADE_EN build)
module tb_shader_fade_sequencer;

  localparam int STEP = 16;
  localparam int HOLD = 1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_shader;
  logic [1:0]  req_kernel;
  logic        frame_start;
  logic        pix_valid_in;
  logic [23:0] pix_rgb_in;
  logic [3:0]  active_shader;
  logic [1:0]  active_kernel;
  logic [7:0]  fade_level;
  logic        busy;
  logic        pix_valid_out;
  logic [23:0] pix_rgb_out;

  int n_cmp = 0;
  int n_bad = 0;

  shader_fade_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_shader    (req_shader),
    .req_kernel    (req_kernel),
    .frame_start   (frame_start),
    .pix_valid_in  (pix_valid_in),
    .pix_rgb_in    (pix_rgb_in),
    .active_shader (active_shader),
    .active_kernel (active_kernel),
    .fade_level    (fade_level),
    .busy          (busy),
    .pix_valid_out (pix_valid_out),
    .pix_rgb_out   (pix_rgb_out)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 fading out, 2 black, 3 fading in
  int          m_sh, m_k, m_fade, m_phase, m_hold;
  logic [23:0] e1_rgb, e2_rgb;
  logic        e1_v, e2_v;

  function automatic logic [23:0] scale(input logic [23:0] rgb, input int f);
    int r, g, b;
    r = (int'(rgb[23:16]) * (f + 1)) / 256;
    g = (int'(rgb[15:8])  * (f + 1)) / 256;
    b = (int'(rgb[7:0])   * (f + 1)) / 256;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic int dn(input int f);
    return (f - STEP < 0) ? 0 : f - STEP;
  endfunction

  function automatic int up(input int f);
    return (f + STEP > 255) ? 255 : f + STEP;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sh = 6; m_k = 0; m_fade = 255; m_phase = 0; m_hold = 0;
      e1_rgb = '0; e2_rgb = '0; e1_v = 1'b0; e2_v = 1'b0;
    end else begin
      bit same;
      e2_rgb = e1_rgb; e2_v = e1_v;
      e1_rgb = scale(pix_rgb_in, m_fade); e1_v = pix_valid_in;
      same = (int'(req_shader) == m_sh) && (int'(req_kernel) == m_k);
      if (frame_start) begin
`ifdef SHADER_FADE_EN
        if (m_phase == 0) begin
          if (!same) begin m_fade = dn(m_fade); m_phase = 1; end
        end else if (m_phase == 1) begin
          if (same) begin m_fade = up(m_fade); m_phase = 3; end
          else begin
            m_fade = dn(m_fade);
            if (m_fade == 0) begin m_phase = 2; m_hold = HOLD; end
          end
        end else if (m_phase == 2) begin
          m_hold = m_hold - 1;
          if (m_hold == 0) begin m_sh = req_shader; m_k = req_kernel; m_phase = 3; end
        end else begin
          if (!same) begin m_fade = dn(m_fade); m_phase = 1; end
          else begin
            m_fade = up(m_fade);
            if (m_fade == 255) m_phase = 0;
          end
        end
`else
        if (!same) begin m_sh = req_shader; m_k = req_kernel; end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("active_shader", active_shader, m_sh);
      chk("active_kernel", active_kernel, m_k);
      chk("fade_level", fade_level, m_fade);
      chk("busy", busy, m_phase != 0);
      chk("pix_valid_out", pix_valid_out, e2_v);
      chk("pix_rgb_out", pix_rgb_out, e2_rgb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    rst_n = 1'b0; req_shader = 4'd6; req_kernel = 2'd0; frame_start = 1'b0;
    pix_valid_in = 1'b0; pix_rgb_in = '0;
    #50;
    chk("rst_active_shader", active_shader, 6);
    chk("rst_active_kernel", active_kernel, 0);
    chk("rst_fade", fade_level, 255);
    chk("rst_busy", busy, 0);
    chk("rst_pix_valid", pix_valid_out, 0);
    chk("rst_pix_rgb", pix_rgb_out, 0);
    tick(); #5 rst_n = 1'b1;
    tick();

    // Steady request: nothing moves
    frames(3);
    chk("idle_shader", active_shader, 6);
    chk("idle_fade", fade_level, 255);

    // Pixel pass-through at full brightness, valid delayed by two
    pix_valid_in = 1'b1; pix_rgb_in = 24'hC80AFF; tick();
    pix_valid_in = 1'b0; pix_rgb_in = 24'hFFFFFF; tick();
    chk("pix_full_rgb", pix_rgb_out, 24'hC80AFF);
    chk("pix_full_valid", pix_valid_out, 1);
    tick();
    chk("pix_valid_drop", pix_valid_out, 0);
    chk("pix_white", pix_rgb_out, 24'hFFFFFF);

    // No commit without frame_start
    req_shader = 4'd3; req_kernel = 2'd1;
    repeat (5) tick();
    chk("hold_no_frame", active_shader, 6);
    frame();
`ifdef SHADER_FADE_EN
    chk("first_fade_step", fade_level, 239);
    chk("first_busy", busy, 1);
    chk("shader_held", active_shader, 6);
    frames(15);
    chk("black_fade", fade_level, 0);
    pix_valid_in = 1'b1; pix_rgb_in = 24'hC8FF01; tick(); tick();
    chk("pix_black", pix_rgb_out, 0);
    pix_valid_in = 1'b0;
`else
    chk("direct_commit", active_shader, 3);
    frames(15);
`endif
    frame();
    chk("commit_shader", active_shader, 3);
    chk("commit_kernel", active_kernel, 1);
    frames(16);
    chk("ramp_done_fade", fade_level, 255);
    chk("ramp_done_busy", busy, 0);

    // Fade-out to 127, then revert
    req_shader = 4'd6; req_kernel = 2'd0;
    frames(8);
`ifdef SHADER_FADE_EN
    chk("mid_fade", fade_level, 127);
    pix_valid_in = 1'b1; pix_rgb_in = 24'hC80000; tick(); tick();
    chk("pix_r200_f127", pix_rgb_out, 24'h640000);
    pix_valid_in = 1'b0;
`endif
    req_shader = 4'd3; req_kernel = 2'd1;
    frame();
`ifdef SHADER_FADE_EN
    chk("revert_fade", fade_level, 143);
`endif
    chk("revert_shader", active_shader, 3);
    frames(8);
    chk("revert_idle", busy, 0);

    // Retarget while black
    req_shader = 4'd7; req_kernel = 2'd0;
    frames(16);
    req_shader = 4'd8; req_kernel = 2'd2;
    frame();
    chk("retarget_shader", active_shader, 8);
    chk("retarget_kernel", active_kernel, 2);
    frames(16);

    // Request change in the same cycle as frame_start
    req_shader = 4'd2; req_kernel = 2'd3; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
`ifndef SHADER_FADE_EN
    chk("same_cycle_commit", active_shader, 2);
`endif
    // Random pixels across a fade with frames every fourth cycle
    for (int i = 0; i < 160; i++) begin
      pix_valid_in = 1'($urandom_range(0, 1));
      pix_rgb_in = 24'($urandom);
      frame_start = (i % 4 == 0);
      if (i == 40) begin req_shader = 4'd9; req_kernel = 2'd0; end
      tick();
    end
    frame_start = 1'b0;

    // Asynchronous reset mid-sequence
    req_shader = 4'd4; req_kernel = 2'd1;
    frames(5);
    pix_valid_in = 1'b1; pix_rgb_in = 24'h123456;
    tick();
    #5 rst_n = 1'b0;
    #1;
    chk("arst_shader", active_shader, 6);
    chk("arst_kernel", active_kernel, 0);
    chk("arst_fade", fade_level, 255);
    chk("arst_busy", busy, 0);
    chk("arst_pix_valid", pix_valid_out, 0);
    chk("arst_pix_rgb", pix_rgb_out, 0);
    #10 rst_n = 1'b1;
    req_shader = 4'd6; req_kernel = 2'd0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
